// File: rtl/main_control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM and the ALU control decoder:
// state enum, ALUOp codes, opcode constants and operand/result select codes.
package main_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  localparam logic [2:0] ALUOP_R      = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_ADD    = 3'b010;
  localparam logic [2:0] ALUOP_IALU   = 3'b011;
  localparam logic [2:0] ALUOP_UPPER  = 3'b100;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Successor of DECODE; anything undecodable lands in the absorbing TRAP state.
  function automatic state_t decode_next(input logic [6:0] opcode, input logic jalr_en);
    state_t nxt;
    case (opcode)
      OPC_LOAD, OPC_STORE: nxt = S_MEMADR;
      OPC_RTYPE:           nxt = S_EXECR;
      OPC_ITYPE:           nxt = S_EXECI;
      OPC_BRANCH:          nxt = S_BRANCH;
      OPC_JAL:             nxt = S_JAL;
      OPC_JALR:            nxt = jalr_en ? S_JALR : S_TRAP;
      OPC_LUI:             nxt = S_LUI;
      OPC_AUIPC:           nxt = S_AUIPC;
      default:             nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle RV32I main control: one state register, next-state logic and
// a state-decoded output block.
module main_control_fsm
  import main_control_fsm_pkg::*;
#(
  parameter int SUPPORT_JALR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       mem_req,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_op,
  output logic       illegal
);

  state_t state, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE:   state_next = decode_next(opcode, SUPPORT_JALR != 0);
      S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH: state_next = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI, S_AUIPC: state_next = S_ALUWB;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  // Outputs are combinational from the state so an async reset clears them at
  // once; the FETCH load strobes are also gated by rst since FETCH is the reset state.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    mem_req    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready & ~rst;
        pc_write   = mem_ready & ~rst;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_R;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_IALU;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_BRANCH;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_UPPER;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_UPPER;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
